// File: rtl/qif_pkg.sv
// Shared types, defaults and helpers for the QIF neuron array.
// sat_signed clamps a wide signed value into the range of a w-bit signed word.
package qif_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } qif_state_t;

    localparam int V_PEAK_DEF  = 50;
    localparam int V_RESET_DEF = -20;

    function automatic longint sat_signed(input longint x, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/qif_neuron_array_if.sv
// Step handshake, drive bus, spike results and membrane readout of the QIF array.
// A step transfers on a rising edge where step_valid and step_ready are both high;
// step_valid while step_ready is low is dropped, and b_in is only sampled on that transfer edge.
interface qif_neuron_array_if #(
    parameter int W    = 8,
    parameter int N_CH = 4
);
    import qif_pkg::*;

    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                    step_valid;
    logic                    step_ready;
    logic [N_CH*W-1:0]       b_in;
    logic [N_CH-1:0]         spike_vec;
    logic                    step_done;
    logic [SEL_W-1:0]        v_sel;
    logic signed [W-1:0]     v_out;
    qif_state_t              state;

    modport master (
        output step_valid, b_in, v_sel,
        input  step_ready, spike_vec, step_done, v_out, state
    );

    modport slave (
        input  step_valid, b_in, v_sel,
        output step_ready, spike_vec, step_done, v_out, state
    );

endinterface

// File: rtl/qif_update_core.sv
// Combinational single-channel QIF update: spike check, refractory hold, or
// saturating integration of V + B/2^B_SHIFT + V^2/2^SQ_SHIFT.
module qif_update_core
    import qif_pkg::*;
#(
    parameter int W        = 8,
    parameter int B_SHIFT  = 2,
    parameter int SQ_SHIFT = 4,
    parameter int V_PEAK   = V_PEAK_DEF,
    parameter int V_RESET  = V_RESET_DEF,
    parameter int REFRAC   = 2,
    parameter int RW       = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1
) (
    input  logic signed [W-1:0] v,
    input  logic signed [W-1:0] b,
    input  logic [RW-1:0]       refrac,
    output logic signed [W-1:0] v_next,
    output logic [RW-1:0]       refrac_next,
    output logic                spike
);
    localparam int XW = 2 * W + 2;
    localparam logic signed [W-1:0] PEAK_W  = W'(V_PEAK);
    localparam logic signed [W-1:0] RESET_W = W'(V_RESET);
    localparam logic [RW-1:0]       REFRAC_R = RW'(REFRAC);

    logic signed [XW-1:0] v_x;
    logic signed [XW-1:0] b_x;
    logic signed [XW-1:0] sq;
    logic signed [XW-1:0] sum;

    // Widened so V*V and the three-term sum can never wrap before saturation.
    assign v_x = {{(XW - W){v[W-1]}}, v};
    assign b_x = {{(XW - W){b[W-1]}}, b};
    assign sq  = v_x * v_x;
    assign sum = v_x + (b_x >>> B_SHIFT) + (sq >>> SQ_SHIFT);

    always_comb begin
        spike       = 1'b0;
        v_next      = v;
        refrac_next = refrac;
        if (v >= PEAK_W) begin
            spike       = 1'b1;
            v_next      = RESET_W;
            refrac_next = REFRAC_R;
        end else if (refrac != '0) begin
            refrac_next = refrac - RW'(1);
            v_next      = RESET_W;
        end else begin
            v_next = W'(sat_signed(64'(sum), W));
        end
    end

endmodule

// File: rtl/qif_neuron_array.sv
// Time-multiplexed array of N_CH QIF neurons sharing one update core; each
// accepted step sweeps the channels one per cycle and then publishes spike_vec.
module qif_neuron_array
    import qif_pkg::*;
#(
    parameter int W        = 8,
    parameter int N_CH     = 4,
    parameter int B_SHIFT  = 2,
    parameter int SQ_SHIFT = 4,
    parameter int V_PEAK   = V_PEAK_DEF,
    parameter int V_RESET  = V_RESET_DEF,
    parameter int REFRAC   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    qif_neuron_array_if.slave  bus
);
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int RW    = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic signed [W-1:0] RESET_W = W'(V_RESET);
    localparam logic [SEL_W-1:0]    LAST_CH = SEL_W'(N_CH - 1);

    qif_state_t          state;
    logic signed [W-1:0] v_mem      [N_CH];
    logic [RW-1:0]       refrac_mem [N_CH];
    logic [SEL_W-1:0]    ch;
    logic [N_CH*W-1:0]   b_hold;
    logic [N_CH-1:0]     acc;
    logic [N_CH-1:0]     acc_next;
    logic [N_CH-1:0]     spike_vec;
    logic                step_done;
    logic                step_ready;
    logic signed [W-1:0] v_out;

    logic signed [W-1:0] core_v_next;
    logic [RW-1:0]       core_r_next;
    logic                core_spike;

    qif_update_core #(
        .W        (W),
        .B_SHIFT  (B_SHIFT),
        .SQ_SHIFT (SQ_SHIFT),
        .V_PEAK   (V_PEAK),
        .V_RESET  (V_RESET),
        .REFRAC   (REFRAC),
        .RW       (RW)
    ) u_core (
        .v           (v_mem[ch]),
        .b           (b_hold[ch*W +: W]),
        .refrac      (refrac_mem[ch]),
        .v_next      (core_v_next),
        .refrac_next (core_r_next),
        .spike       (core_spike)
    );

    // Folds the current channel's spike in so the last channel lands in spike_vec directly.
    always_comb begin
        acc_next     = acc;
        acc_next[ch] = core_spike;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                v_mem[i]      <= RESET_W;
                refrac_mem[i] <= '0;
            end
            state      <= IDLE;
            ch         <= '0;
            b_hold     <= '0;
            acc        <= '0;
            spike_vec  <= '0;
            step_done  <= 1'b0;
            step_ready <= 1'b1;
            v_out      <= RESET_W;
        end else begin
            step_done <= 1'b0;
            v_out     <= (int'(bus.v_sel) < N_CH) ? v_mem[bus.v_sel] : '0;
            case (state)
                IDLE: begin
                    if (bus.step_valid && step_ready) begin
                        b_hold     <= bus.b_in;
                        ch         <= '0;
                        acc        <= '0;
                        step_ready <= 1'b0;
                        state      <= UPDATE;
                    end
                end
                UPDATE: begin
                    v_mem[ch]      <= core_v_next;
                    refrac_mem[ch] <= core_r_next;
                    acc            <= acc_next;
                    if (ch == LAST_CH) begin
                        spike_vec <= acc_next;
                        step_done <= 1'b1;
                        state     <= DONE;
                    end else begin
                        ch <= ch + SEL_W'(1);
                    end
                end
                DONE: begin
                    step_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    step_ready <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.step_ready = step_ready;
    assign bus.spike_vec  = spike_vec;
    assign bus.step_done  = step_done;
    assign bus.v_out      = v_out;
    assign bus.state      = state;

endmodule

// File: tb/tb_qif_neuron_array.sv
// Self-checking bench for qif_neuron_array: directed scenarios plus random steps
// compared against an arithmetic QIF model.
module tb_qif_neuron_array;
    import qif_pkg::*;

    localparam int W    = 8;
    localparam int N_CH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;

    int mv [N_CH];
    int mr [N_CH];
    logic [N_CH-1:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    qif_neuron_array_if #(.W(W), .N_CH(N_CH)) bus ();

    qif_neuron_array #(.W(W), .N_CH(N_CH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // reference model
    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            mv[c] = -20;
            mr[c] = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_step(input logic [N_CH*W-1:0] b);
        logic [N_CH-1:0]     sp;
        logic signed [W-1:0] bf;
        int n;
        sp = '0;
        for (int c = 0; c < N_CH; c++) begin
            bf = b[c*W +: W];
            if (mv[c] >= 50) begin
                sp[c] = 1'b1;
                mv[c] = -20;
                mr[c] = 2;
            end else if (mr[c] > 0) begin
                mr[c] = mr[c] - 1;
                mv[c] = -20;
            end else begin
                n = mv[c] + (int'(bf) >>> 2) + ((mv[c] * mv[c]) >>> 4);
                if (n > 127)  n = 127;
                if (n < -128) n = -128;
                mv[c] = n;
            end
        end
        exp_q.push_back(sp);
    endtask

    // drivers
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic read_v(input int c, output int val);
        @(negedge clk);
        bus.v_sel = 2'(c);
        @(negedge clk);
        val = int'(bus.v_out);
    endtask

    task automatic check_all_v(input string tag);
        int val;
        for (int c = 0; c < N_CH; c++) begin
            read_v(c, val);
            check($sformatf("%s_v%0d", tag, c), val, mv[c]);
        end
    endtask

    // mode 0: plain step, 1: valid held and b_in changed mid-sweep, 2: reset mid-sweep
    task automatic do_step(input logic [N_CH*W-1:0] b, input int mode);
        int waited;
        int dones;
        int done_cyc;
        int rdy_low;
        logic [N_CH-1:0] exp_sp;
        waited   = 0;
        dones    = 0;
        done_cyc = -1;
        rdy_low  = 0;
        @(negedge clk);
        while (!bus.step_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", int'(waited < 20), 1);
        bus.b_in       = b;
        bus.step_valid = 1'b1;
        @(posedge clk);
        model_step(b);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (mode != 1 || k >= 5) bus.step_valid = 1'b0;
            if (mode == 1 && k == 2) bus.b_in = ~b;
            if (mode == 2 && k == 2) begin
                rst_n = 1'b0;
                #1;
                check("rst_mid_ready", int'(bus.step_ready), 1);
                check("rst_mid_done", int'(bus.step_done), 0);
                model_reset();
            end
            if (mode == 2 && k == 3) rst_n = 1'b1;
            if (k <= 5 && !bus.step_ready) rdy_low++;
            if (bus.step_done) begin
                dones++;
                done_cyc = k;
                exp_sp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                check("spike_vec", int'(bus.spike_vec), int'(exp_sp));
            end
        end
        if (mode == 2) begin
            check("rst_mid_no_done", dones, 0);
        end else begin
            check("done_count", dones, 1);
            check("done_latency", done_cyc, 5);
            check("ready_low_cycles", rdy_low, 5);
        end
    endtask

    function automatic logic [N_CH*W-1:0] rand_b();
        logic [N_CH*W-1:0] r;
        for (int c = 0; c < N_CH; c++) r[c*W +: W] = W'($urandom_range(0, 255));
        return r;
    endfunction

    initial begin
        int val;
        int v2_exp [6];
        int sp_exp [6];
        v2_exp = '{36, 127, -20, -20, -20, 36};
        sp_exp = '{0, 0, 4, 0, 0, 0};

        bus.step_valid = 1'b0;
        bus.b_in       = '0;
        bus.v_sel      = '0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_ready", int'(bus.step_ready), 1);
        check("reset_done", int'(bus.step_done), 0);
        check("reset_spike", int'(bus.spike_vec), 0);
        for (int c = 0; c < N_CH; c++) begin
            read_v(c, val);
            check($sformatf("reset_v%0d", c), val, -20);
        end
        rst_n = 1'b1;

        do_step('0, 0);
        check_all_v("zero");
        read_v(1, val);
        check("zero_v1_lit", val, 5);
        check("zero_spike_lit", int'(bus.spike_vec), 0);

        apply_reset();
        for (int s = 0; s < 6; s++) begin
            do_step(32'(127) << 16, 0);
            read_v(2, val);
            check($sformatf("drive2_s%0d_v2", s + 1), val, v2_exp[s]);
            check($sformatf("drive2_s%0d_spk", s + 1), int'(bus.spike_vec), sp_exp[s]);
            check_all_v($sformatf("drive2_s%0d", s + 1));
        end

        do_step(rand_b(), 1);
        check_all_v("hold_valid");

        do_step(rand_b(), 2);
        check_all_v("rst_mid");
        do_step('0, 0);
        check_all_v("after_rst");

        for (int s = 0; s < 25; s++) begin
            do_step(rand_b(), 0);
            check_all_v($sformatf("rand%0d", s));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
